dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the memory stage. The memory stage issues load/store
//  requests; this block latches each request, waits a fixed latency, then returns
//  a one-cycle mem_ready pulse with load data or an error flag. The memory stage
//  holds pc_src and the pipeline until mem_ready. Byte-addressed, doubleword
//  accesses only, backed by an internal register array.
// PARAMETERS
//  WIDTH    `WORD (64)  data word width in bits
//  DEPTH    128         number of WIDTH-bit words; power of 2
//  LATENCY  2           cycles from accept to mem_ready; legal range 1..15
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous active-low reset
//  mem_read        in   1      load request strobe; held until mem_ready
//  mem_write       in   1      store request strobe; held until mem_ready
//  mem_address     in   WIDTH  byte address
//  mem_write_data  in   WIDTH  store data
//  mem_read_data   out  WIDTH  load data; valid when mem_ready=1 and mem_error=0
//  mem_ready       out  1      one-cycle response pulse
//  mem_busy        out  1      1 while a request is in flight (BUSY or RESP)
//  mem_error       out  1      qualifies mem_ready: request was rejected
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Outputs go to 0; FSM goes to IDLE; latency counter clears.
//   - All DEPTH words clear to 0.
//  FSM states:
//   IDLE -> BUSY  when (mem_read|mem_write) is sampled. The request is accepted:
//                 address, write data, and type are captured; cnt = LATENCY-1.
//   BUSY: cnt decrements each cycle. BUSY -> RESP when cnt==0.
//         With LATENCY=1, BUSY is skipped and IDLE -> RESP directly.
//   RESP -> IDLE unconditionally. mem_ready=1 for exactly this cycle.
//  Latency: a request accepted on edge T gives mem_ready high during
//   cycle T+LATENCY. Inputs change only on the captured copies.
//  Error and address checks (evaluated on the captured request):
//   - mem_read & mem_write both 1 -> error.
//   - mem_address[2:0] != 0 (misaligned) -> error.
//   - mem_address[WIDTH-1:3] >= DEPTH (out of range) -> error.
//   - On error, RESP asserts mem_error=1, no store is done, and
//     mem_read_data=0.
//  Store: mem[addr[3 +: log2(DEPTH)]] <= data on the RESP edge.
//  Load: mem_read_data is updated on entry to RESP and is held until the next
//   load or error response. A store leaves mem_read_data unchanged.
//  Inputs in BUSY/RESP are ignored; the captured copy governs. A request still
//   high in the IDLE cycle after RESP is treated as a new request (back-to-back).
//  mem_busy = (state != IDLE). mem_error is 0 whenever mem_ready=0.
//  Reset mid-operation aborts the request: no store, and outputs return to 0.
// TESTING
//  1. Reset, then load addr 0x0 (LATENCY=2) -> mem_ready at T+2,
//     mem_read_data=0, mem_error=0.
//  2. Store 0xDEADBEEF_CAFEF00D to 0x18, then load 0x18 ->
//     second response returns 0xDEADBEEF_CAFEF00D; mem_busy high 2 cycles each.
//  3. Load 0x1C (misaligned), and separately load 0x400 with DEPTH=128 ->
//     mem_ready & mem_error; read data 0; memory unchanged.
//  4. mem_read=mem_write=1 at 0x8 -> error response; word 0x8 unchanged.
//  5. Store to 0x20, then change address/data mid-BUSY -> only original
//     0x20/data committed. Drop rst_n during BUSY of a store to 0x28 ->
//     no mem_ready; 0x28 reads 0.
//  6. LATENCY=1 and LATENCY=15 builds: back-to-back loads -> ready pulses
//     spaced LATENCY+1 cycles apart; each pulse is exactly 1 cycle wide.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one doubleword load/store request, waits LATENCY
// cycles, then pulses mem_ready with load data or an error flag.
module dmem_responder #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_write_data,
  output logic [WIDTH-1:0] mem_read_data,
  output logic             mem_ready,
  output logic             mem_busy,
  output logic             mem_error
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             cap_read, cap_write;
  logic [WIDTH-1:0] cap_addr, cap_data;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept, src_read, src_write, src_err, do_store;
  logic [WIDTH-1:0] src_addr, addr_hi;
  logic [AW-1:0]    src_idx;

  assign accept = (state == IDLE) && (mem_read || mem_write);

  // With LATENCY=1 the response is produced on the accept edge itself, so the
  // checks must look at the live request in IDLE and the captured copy afterwards.
  assign src_read  = (state == IDLE) ? mem_read    : cap_read;
  assign src_write = (state == IDLE) ? mem_write   : cap_write;
  assign src_addr  = (state == IDLE) ? mem_address : cap_addr;

  assign addr_hi  = src_addr >> (3 + AW);
  assign src_err  = (src_read && src_write) || (src_addr[2:0] != 3'd0) || (addr_hi != '0);
  assign src_idx  = src_addr[3 +: AW];
  assign do_store = (state == RESP) && src_write && !src_err;
  assign mem_busy = (state != IDLE);

  // cnt counts down to the RESP entry; RESP is entered LATENCY-1 edges after accept
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = CNT_INIT;
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
      mem_read_data <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ready <= (state_nxt == RESP);
      mem_error <= (state_nxt == RESP) && src_err;
      if (state_nxt == RESP) begin
        if (src_err)       mem_read_data <= '0;
        else if (src_read) mem_read_data <= mem[src_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_read  <= mem_read;
      cap_write <= mem_write;
      cap_addr  <= mem_address;
      cap_data  <= mem_write_data;
    end
  end

  // Stores commit on the edge leaving RESP, so a reset in flight drops them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_store) begin
      mem[src_idx] <= cap_data;
    end
  end

endmodule
